// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port memory between the IF-stage fetch port
//            and the MEM-stage data port. Each access takes a fixed latency.
//            The optional macro MEM_ARB_RR_EN enables round-robin arbitration
//            when both ports request together.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic [DATA_W-1:0] ifRdata,
    output logic              ifAck,
    output logic              ifStall,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic [DATA_W-1:0] dRdata,
    output logic              dAck,
    output logic              memCe,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic       OWN_IF   = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    localparam logic [3:0] C_LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state_q,    state_d;
    logic [3:0]        count_q,    count_d;
    logic              owner_q,    owner_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              we_q,       we_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic              if_ack_q,   if_ack_d;
    logic              d_ack_q,    d_ack_d;
    logic              mem_ce_q,   mem_ce_d;
    logic              grant;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the port that lost the previous grant wins.
    always_comb begin
        if (dReq && ifReq) grant = ~last_q;
        else               grant = dReq ? OWN_D : OWN_IF;
    end
`else
    always_comb grant = dReq ? OWN_D : OWN_IF;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        mem_ce_d   = mem_ce_q;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (dReq || ifReq) begin
                    owner_d  = grant;
                    count_d  = C_LAT_M1;
                    mem_ce_d = 1'b1;
                    state_d  = S_ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_d   = grant;
`endif
                    if (grant == OWN_D) begin
                        addr_d  = dAddr;
                        we_d    = dWe;
                        wdata_d = dWdata;
                    end else begin
                        addr_d  = ifAddr;
                        we_d    = 1'b0;
                    end
                end
            end
            S_ACCESS: begin
                if (count_q == 4'd0) begin
                    mem_ce_d = 1'b0;
                    state_d  = S_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = memRdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        if (!we_q) d_rdata_d = memRdata;
                        d_ack_d = 1'b1;
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                mem_ce_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= 4'd0;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            mem_ce_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q     <= OWN_D;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            mem_ce_q   <= mem_ce_d;
`ifdef MEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign ifRdata  = if_rdata_q;
    assign ifAck    = if_ack_q;
    assign ifStall  = ifReq & ~if_ack_q;
    assign dRdata   = d_rdata_q;
    assign dAck     = d_ack_q;
    assign memCe    = mem_ce_q;
    assign memWe    = mem_ce_q & we_q;
    assign memAddr  = mem_ce_q ? addr_q  : '0;
    assign memWdata = mem_ce_q ? wdata_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter (MEM_LAT=2 and MEM_LAT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    // MEM_LAT = 2 instance
    logic        ifReq, dReq, dWe;
    logic [31:0] ifAddr, dAddr, dWdata;
    logic [31:0] ifRdata, dRdata, memAddr, memWdata, memRdata;
    logic        ifAck, ifStall, dAck, memCe, memWe;
    // MEM_LAT = 1 instance
    logic        l1_ifReq, l1_dReq, l1_dWe;
    logic [31:0] l1_ifAddr, l1_dAddr, l1_dWdata;
    logic [31:0] l1_ifRdata, l1_dRdata, l1_memAddr, l1_memWdata, l1_memRdata;
    logic        l1_ifAck, l1_ifStall, l1_dAck, l1_memCe, l1_memWe;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic        port;   // 1 = data, 0 = fetch
        logic [31:0] data;
        int          t0;
        int          lat;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h10) ? 32'h2001_0005 : ((a ^ 32'hA5A5_0000) + 32'h1);
    endfunction

    assign memRdata    = mem_model(memAddr);
    assign l1_memRdata = mem_model(l1_memAddr);

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifAck(ifAck), .ifStall(ifStall),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dRdata(dRdata), .dAck(dAck),
        .memCe(memCe), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memRdata(memRdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .ifReq(l1_ifReq), .ifAddr(l1_ifAddr), .ifRdata(l1_ifRdata), .ifAck(l1_ifAck),
        .ifStall(l1_ifStall),
        .dReq(l1_dReq), .dWe(l1_dWe), .dAddr(l1_dAddr), .dWdata(l1_dWdata), .dRdata(l1_dRdata),
        .dAck(l1_dAck),
        .memCe(l1_memCe), .memWe(l1_memWe), .memAddr(l1_memAddr), .memWdata(l1_memWdata),
        .memRdata(l1_memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] data, input int t0, input int lat);
        exp_t e;
        e.port = port; e.data = data; e.t0 = t0; e.lat = lat;
        sb.push_back(e);
    endtask

    // Waits for the next ack on the MEM_LAT=2 instance and scores it.
    task automatic wait_ack(input int budget, output logic port);
        bit   got;
        exp_t e;
        got  = 1'b0;
        port = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (dAck || ifAck) begin
                got  = 1'b1;
                port = dAck;
                chk("ack_exclusive", 32'(dAck & ifAck), 32'd0);
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_ack: observed dAck=%0b ifAck=%0b expected none", dAck, ifAck);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", 32'(dAck), 32'(e.port));
                    chk("ack_data", dAck ? dRdata : ifRdata, e.data);
                    chk("ack_latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $error("FAIL ack_timeout: observed no ack expected ack within %0d cycles", budget);
        end
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        p;
        logic [31:0] last_drdata;
        logic [31:0] d_ports;
        int          t0, t_prev, n_ack, n_ce;

        rst = 1'b0;
        ifReq = 0; dReq = 0; dWe = 0; ifAddr = 0; dAddr = 0; dWdata = 0;
        l1_ifReq = 0; l1_dReq = 0; l1_dWe = 0; l1_ifAddr = 0; l1_dAddr = 0; l1_dWdata = 0;

        // Reset state and combinational stall
        repeat (2) @(negedge clk);
        chk("rst_memCe",   32'(memCe), 0);
        chk("rst_memWe",   32'(memWe), 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_ifAck",   32'(ifAck), 0);
        chk("rst_dAck",    32'(dAck), 0);
        chk("rst_ifRdata", ifRdata, 0);
        chk("rst_dRdata",  dRdata, 0);
        ifReq = 1'b1;
        #1 chk("rst_ifStall_hi", 32'(ifStall), 1);
        ifReq = 1'b0;
        #1 chk("rst_ifStall_lo", 32'(ifStall), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single fetch
        ifReq = 1'b1; ifAddr = 32'h10;
        push(1'b0, 32'h2001_0005, cyc, 3);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("fetch_memCe",   32'(memCe), 1);
            chk("fetch_memAddr", memAddr, 32'h10);
            chk("fetch_memWe",   32'(memWe), 0);
            chk("fetch_ifStall", 32'(ifStall), 1);
        end
        wait_ack(8, p);
        chk("fetch_ifStall_ack", 32'(ifStall), 0);
        chk("fetch_memCe_resp",  32'(memCe), 0);
        ifReq = 1'b0;
        @(negedge clk);
        chk("fetch_ack_pulse", 32'(ifAck), 0);
        chk("idle_memAddr",    memAddr, 0);

        // Both requests held for four grants; previous grant was the fetch
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h80;
        ifReq = 1'b1; ifAddr = 32'h20;
`ifdef MEM_ARB_RR_EN
        d_ports = 32'b1010;
`else
        d_ports = 32'b1111;
`endif
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            push(d_ports[3-i], d_ports[3-i] ? mem_model(32'h80) : mem_model(32'h20), t0, 3 + 4 * i);
        end
        for (int i = 0; i < 4; i++) wait_ack(12, p);
        dReq = 1'b0; ifReq = 1'b0;
        @(negedge clk);

        // Simultaneous requests: data first, fetch in the following IDLE
        dReq = 1'b1; dAddr = 32'h80;
        ifReq = 1'b1; ifAddr = 32'h20;
        push(1'b1, mem_model(32'h80), cyc, 3);
        push(1'b0, mem_model(32'h20), cyc, 7);
        wait_ack(8, p);
        if (p) dReq = 1'b0;
        wait_ack(8, p);
        ifReq = 1'b0; dReq = 1'b0;
        last_drdata = mem_model(32'h80);
        @(negedge clk);

        // Store: dRdata must keep its previous value
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h40; dWdata = 32'hDEAD_BEEF;
        push(1'b1, last_drdata, cyc, 3);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("store_memWe",    32'(memWe), 1);
            chk("store_memWdata", memWdata, 32'hDEAD_BEEF);
            chk("store_memAddr",  memAddr, 32'h40);
        end
        wait_ack(8, p);
        chk("store_memWe_resp", 32'(memWe), 0);
        dReq = 1'b0; dWe = 1'b0;
        @(negedge clk);

        // Reset in the first access cycle of a fetch
        ifReq = 1'b1; ifAddr = 32'h30;
        @(negedge clk);
        chk("midrst_memCe_before", 32'(memCe), 1);
        #1 rst = 1'b0;
        #1 chk("midrst_memCe_async", 32'(memCe), 0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_ack", 32'(ifAck), 0);
            chk("midrst_memCe",  32'(memCe), 0);
        end
        rst = 1'b1;
        push(1'b0, mem_model(32'h30), cyc, 3);
        wait_ack(8, p);
        ifReq = 1'b0;
        @(negedge clk);

        // MEM_LAT=1: back-to-back fetches with the request held
        l1_ifReq = 1'b1; l1_ifAddr = 32'h100;
        t_prev = cyc; n_ack = 0; n_ce = 0;
        for (int i = 0; i < 15 && n_ack < 3; i++) begin
            @(negedge clk);
            if (l1_memCe) begin
                n_ce++;
                chk("l1_memAddr", l1_memAddr, 32'h100 + 32'(4 * n_ack));
            end
            if (l1_ifAck) begin
                chk("l1_ce_per_access", 32'(n_ce), 1);
                chk("l1_data", l1_ifRdata, mem_model(32'h100 + 32'(4 * n_ack)));
                chk("l1_ack_spacing", 32'(cyc - t_prev), (n_ack == 0) ? 32'd2 : 32'd3);
                t_prev = cyc;
                n_ce = 0;
                n_ack++;
                l1_ifAddr = 32'h100 + 32'(4 * n_ack);
                if (n_ack == 3) l1_ifReq = 1'b0;
            end
        end
        chk("l1_ack_count", 32'(n_ack), 3);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (load/store stage) of the MIPS core.
- Sequences each access over a fixed memory latency, returns read data, and generates a stall to the IF stage while a fetch is outstanding.
- Sits between the core's IF/MEM stages and the external memory model.

Parameters:
- ADDR_W, 32, address width of both requesters and memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory access cycles; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- ifReq  input  1  fetch request; held until ifAck.
- ifAddr  input  ADDR_W  fetch address.
- ifRdata  output  DATA_W  fetched instruction, valid when ifAck=1.
- ifAck  output  1  one-cycle fetch completion pulse.
- ifStall  output  1  ifReq & ~ifAck (combinational).
- dReq  input  1  data request; held until dAck.
- dWe  input  1  1 = write, 0 = read.
- dAddr  input  ADDR_W  data address.
- dWdata  input  DATA_W  write data.
- dRdata  output  DATA_W  load data, valid when dAck=1 on reads.
- dAck  output  1  one-cycle data completion pulse.
- memCe  output  1  memory enable.
- memWe  output  1  memory write enable.
- memAddr  output  ADDR_W  memory address.
- memWdata  output  DATA_W  memory write data.
- memRdata  input  DATA_W  memory read data, valid in last access cycle.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst=0 resets immediately, independent of clk).
- Reset values:
  - state=IDLE; count=0; owner=IF; last-granted=DATA.
  - All outputs 0 except ifStall, which follows ifReq.
- FSM IDLE:
  - No request pending: stay.
  - dReq=1: grant DATA. Data outranks fetch because it is the older instruction.
  - Otherwise ifReq=1: grant IF.
  - On grant: latch address, we and wdata into internal registers, load count=MEM_LAT-1, go to ACCESS.
- FSM ACCESS:
  - memCe=1; memAddr, memWe and memWdata driven from the latched registers.
  - memWe=1 only for DATA writes.
  - count decrements each cycle.
  - When count=0: capture memRdata into ifRdata (IF read) or dRdata (DATA read), then go to RESP.
  - Occupies exactly MEM_LAT cycles.
- FSM RESP:
  - memCe=0; owner's ack=1 for one cycle; next state IDLE.
- Latency:
  - Request sampled in IDLE in cycle N; ack high in cycle N+MEM_LAT+1.
  - Minimum spacing between two grants is MEM_LAT+2 cycles.
- Request-rule violations:
  - Requester drops req during ACCESS: the access still completes and ack still pulses.
  - Inputs changing during ACCESS are ignored, since they are latched at grant.
- New requests: req high in the IDLE cycle after an ack is a new request.
- Read-data registers:
  - ifRdata and dRdata hold their last value until overwritten.
  - dRdata is unchanged by writes.
- Width rules: count is 4 bits; MEM_LAT=1 means one ACCESS cycle with the count=0 capture.
- ifStall is purely combinational, with no registered state.
- Reset mid-ACCESS:
  - Access abandoned, memCe=0 at once, no ack produced.
  - Requesters re-issue after reset.
- memCe, memWe and memAddr are 0 in IDLE and RESP.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - When both dReq and ifReq are high in IDLE, grant the port not granted last; the last-granted register updates at every grant.
  - Single requests are granted as usual.
  - Prevents a load/store stream from starving fetch.
- Undefined: fixed priority, DATA over IF; the last-granted register is not implemented.

Test Plan:
- Fetch: MEM_LAT=2; rst released; ifReq=1, ifAddr=0x0000_0010, memRdata=0x2001_0005 during the access.
  - memCe=1 for exactly 2 cycles with memAddr=0x10, memWe=0.
  - ifAck pulses 3 cycles after the request, with ifRdata=0x2001_0005.
  - ifStall=1 until ifAck.
- Simultaneous requests, fixed priority (macro off): ifReq=dReq=1 in the same cycle.
  - DATA is served first, dAck at +3.
  - IF is granted in the IDLE cycle that follows, ifAck at +7.
- Store: dWe=1, dAddr=0x40, dWdata=0xDEAD_BEEF.
  - memWe=1 with memWdata=0xDEAD_BEEF for MEM_LAT cycles.
  - dAck pulses; dRdata keeps its prior value.
- Round robin (MEM_ARB_RR_EN defined): both req held high continuously for 4 grants.
  - Grant order is DATA, IF, DATA, IF.
  - With the macro off, the order is DATA, DATA, DATA, DATA.
- Reset mid-access: assert rst=0 in the first ACCESS cycle of a fetch.
  - memCe=0 immediately, no ifAck, state IDLE.
  - After release, the held ifReq is re-granted and completes normally.
- MEM_LAT=1, back-to-back fetches:
  - ifAck every 3 cycles.
  - memCe is a single-cycle pulse per access.
